usb_rx_ctrl: RTL
================

USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 Parameter: MAX_BYTES, 64, maximum payload bytes per packet after SYNC.
REQ-002 clk  input  1  system clock, all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 d_plus  input  1  synchronized USB D+ line.
REQ-005 d_minus  input  1  synchronized USB D- line.
REQ-006 shift_enable  input  1  one-cycle bit-sample strobe from the bit timer.
REQ-007 reset_timer  output  1  holds the bit timer in resync while high.
REQ-008 rcv_data  output  8  last completed byte, LSB received first.
REQ-009 byte_valid  output  1  one-cycle pulse when rcv_data updates.
REQ-010 rx_active  output  1  high from SYNC start to EOP completion.
REQ-011 eop  output  1  one-cycle pulse on valid end-of-packet.
REQ-012 rx_error  output  1  sticky packet error flag.

Function
REQ-013 Line states, evaluated only on shift_enable=1: J = (d_plus=1, d_minus=0); K = (0,1); SE0 = (0,0).
REQ-014 States SHALL be IDLE, SYNC, RECEIVE, EOP_WAIT, ERROR.
REQ-015 IDLE: reset_timer=1, rx_active=0; d_plus 1->0 between consecutive clk cycles SHALL go to SYNC and drop reset_timer on the next cycle.
REQ-016 NRZI decode: on each non-SE0 sample, bit = 1 when d_plus equals the previous sampled d_plus, else 0; previous d_plus initialized to 1 on entering SYNC.
REQ-017 Bit unstuffing: the sample after six consecutive decoded 1s SHALL be discarded; if that bit is 1, go to ERROR.
REQ-018 Shift register shifts right, new bit into bit 7; bit counter 0..7 wraps to 0 after 8 kept bits.
REQ-019 SYNC: after 8 kept bits, shift register = 8'h80 -> RECEIVE; any other value -> ERROR.
REQ-020 RECEIVE: on the 8th kept bit, rcv_data loads the shift register and byte_valid pulses in the following cycle; byte_count increments, saturating.
REQ-021 A byte completing when byte_count = MAX_BYTES SHALL go to ERROR without asserting byte_valid.
REQ-022 SE0 in RECEIVE -> EOP_WAIT; if bit counter != 0, rx_error SHALL be set.
REQ-023 EOP_WAIT: a J sample pulses eop (only if rx_error=0) and returns to IDLE; a K sample -> ERROR.
REQ-024 ERROR: rx_error=1; stays until SE0 followed by J, then IDLE without eop.
REQ-025 rx_error SHALL clear only on entry to SYNC or reset.
REQ-026 rx_active SHALL be 1 in SYNC, RECEIVE, EOP_WAIT, ERROR.
REQ-027 SE0 in SYNC -> ERROR; shift_enable absent -> state and counters hold.

Reset
REQ-028 rst=1 at a clk edge SHALL force IDLE, reset_timer=1, rcv_data=0, byte_valid=0, rx_active=0, eop=0, rx_error=0, all counters 0, previous d_plus=1; rst overrides any mid-packet activity.

Structure
REQ-029 Shared package usb_pkg SHALL hold the state enum, SYNC_BYTE=8'h80, STUFF_LIMIT=6, and line-state encodings.
REQ-030 One sub-module, usb_nrzi_decoder, SHALL perform NRZI decode, ones counting and stuff-bit discard, outputting bit, bit_valid, stuff_error.

Verification
REQ-031 Reset mid-RECEIVE -> next cycle all outputs at reset values, state IDLE.
REQ-032 SYNC + byte 8'hA5 + SE0,SE0,J -> byte_valid once with rcv_data=8'hA5, then eop pulse, rx_error=0.
REQ-033 Byte 8'hFF with correct stuffed 0 -> rcv_data=8'hFF, no error; stuffed bit sent as 1 -> rx_error=1, no eop.
REQ-034 Bad SYNC (decoded 8'h40) -> ERROR, rx_error=1, no byte_valid; recovery after SE0,J then new good packet clears rx_error.
REQ-035 SE0 after 5 bits of second byte -> rx_error=1, eop not pulsed, IDLE after J.
REQ-036 MAX_BYTES=2, send 3 bytes -> two byte_valid pulses, rx_error=1 at third byte completion.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB receive controller: FSM states, SYNC
// pattern, bit-stuffing limit and line-state encodings.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RECEIVE,
    ST_EOP_WAIT,
    ST_ERROR
  } state_t;

  // Decoded SYNC field (KJKJKJKK, LSB first) as seen in the shift register.
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Number of consecutive decoded ones after which a stuffed zero follows.
  localparam int STUFF_LIMIT = 6;

  // Line states encoded as {d_plus, d_minus}.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_t;

endpackage

// File: rtl/usb_nrzi_decoder.sv
// NRZI decoder with ones counting and stuffed-bit removal. Outputs are
// combinational from the current sample and the stored line history.
module usb_nrzi_decoder
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sample,
  input  logic d_plus,
  output logic data_bit,
  output logic bit_valid,
  output logic stuff_error
);

  logic       prev_dp;
  logic [2:0] ones_cnt;
  logic       stuff_slot;

  // A decoded one means no transition since the previous sample.
  assign data_bit    = (d_plus == prev_dp);
  assign stuff_slot  = (ones_cnt == 3'(STUFF_LIMIT));
  assign bit_valid   = sample && !stuff_slot;
  assign stuff_error = sample && stuff_slot && data_bit;

  // Track previous line level and run length of decoded ones.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_dp  <= 1'b1;
      ones_cnt <= '0;
    end else if (sample) begin
      prev_dp <= d_plus;
      if (stuff_slot || !data_bit)
        ones_cnt <= '0;
      else
        ones_cnt <= ones_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB low-level receive controller: detects packet start, checks SYNC,
// assembles bytes, and validates end-of-packet, flagging packet errors.
module usb_rx_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       shift_enable,
  output logic       reset_timer,
  output logic [7:0] rcv_data,
  output logic       byte_valid,
  output logic       rx_active,
  output logic       eop,
  output logic       rx_error
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);

  state_t           state, state_next;
  line_t            line;
  logic             is_se0, is_j, is_k;
  logic             d_plus_q;
  logic             dec_sample, dec_clear;
  logic             data_bit, bit_valid, stuff_error;
  logic [2:0]       bit_cnt;
  // Upper seven bits of the shift register; bit 0 always falls off on the
  // next shift, so only the bits that survive into a byte are stored.
  logic [6:0]       shreg_hi;
  logic [7:0]       shreg_next;
  logic [CNT_W-1:0] byte_count;
  logic             se0_seen;
  logic             byte_done;
  logic             byte_load;
  logic             eop_set;
  logic             err_set;

  assign line       = line_t'({d_plus, d_minus});
  assign is_se0     = (line == LINE_SE0);
  assign is_j       = (line == LINE_J);
  assign is_k       = (line == LINE_K);

  assign dec_sample = shift_enable && !is_se0 &&
                      ((state == ST_SYNC) || (state == ST_RECEIVE));
  assign dec_clear  = (state == ST_IDLE);
  assign shreg_next = {data_bit, shreg_hi};
  assign byte_done  = bit_valid && (bit_cnt == 3'd7);

  usb_nrzi_decoder u_nrzi (
    .clk         (clk),
    .rst         (rst),
    .clear       (dec_clear),
    .sample      (dec_sample),
    .d_plus      (d_plus),
    .data_bit    (data_bit),
    .bit_valid   (bit_valid),
    .stuff_error (stuff_error)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next  = state;
    byte_load   = 1'b0;
    eop_set     = 1'b0;
    err_set     = 1'b0;
    reset_timer = (state == ST_IDLE);
    rx_active   = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (d_plus_q && !d_plus) state_next = ST_SYNC;
      end
      ST_SYNC: begin
        if (shift_enable) begin
          if (is_se0 || stuff_error)
            state_next = ST_ERROR;
          else if (byte_done)
            state_next = (shreg_next == SYNC_BYTE) ? ST_RECEIVE : ST_ERROR;
        end
      end
      ST_RECEIVE: begin
        if (shift_enable) begin
          if (is_se0) begin
            state_next = ST_EOP_WAIT;
            err_set    = (bit_cnt != 3'd0);
          end else if (stuff_error) begin
            state_next = ST_ERROR;
          end else if (byte_done) begin
            if (byte_count == CNT_W'(MAX_BYTES)) state_next = ST_ERROR;
            else                                 byte_load  = 1'b1;
          end
        end
      end
      ST_EOP_WAIT: begin
        if (shift_enable) begin
          if (is_j) begin
            state_next = ST_IDLE;
            eop_set    = !rx_error;
          end else if (is_k) begin
            state_next = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (shift_enable && is_j && se0_seen) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Byte assembly, counters, output strobes and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_plus_q   <= 1'b1;
      bit_cnt    <= '0;
      shreg_hi   <= '0;
      byte_count <= '0;
      se0_seen   <= 1'b0;
      rcv_data   <= '0;
      byte_valid <= 1'b0;
      eop        <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      d_plus_q   <= d_plus;
      byte_valid <= byte_load;
      eop        <= eop_set;
      if (byte_load) begin
        rcv_data <= shreg_next;
        if (byte_count != CNT_W'(MAX_BYTES)) byte_count <= byte_count + 1'b1;
      end
      if (state == ST_IDLE) begin
        bit_cnt    <= '0;
        shreg_hi   <= '0;
        byte_count <= '0;
        se0_seen   <= 1'b0;
        if (state_next == ST_SYNC) rx_error <= 1'b0;
      end else begin
        if (bit_valid) begin
          shreg_hi <= shreg_next[7:1];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (state == ST_ERROR && shift_enable) begin
          if (is_se0)    se0_seen <= 1'b1;
          else if (is_k) se0_seen <= 1'b0;
        end
        if (err_set || state_next == ST_ERROR) rx_error <= 1'b1;
      end
    end
  end

endmodule
